// File: rtl/mac_frame_sequencer_pkg.sv
// Shared types and helpers for the frame-sequenced multiply-accumulate block.
package mac_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ACC_W_DEF  = 32;
  localparam int EXT_W      = 64;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    FLUSH,
    OUT
  } state_t;

  // Widens the low val_w bits of val to EXT_W bits, sign- or zero-extending.
  function automatic logic [EXT_W-1:0] ext(input logic [EXT_W-1:0] val,
                                           input int                val_w,
                                           input logic              is_signed);
    logic [EXT_W-1:0] mask;
    logic             sign;
    mask = (val_w >= EXT_W) ? '1 : ((EXT_W'(1) << val_w) - EXT_W'(1));
    sign = |(val & (EXT_W'(1) << (val_w - 1)));
    if (is_signed && sign) ext = val | ~mask;
    else                   ext = val & mask;
  endfunction

endpackage

// File: rtl/mac_frame_sequencer_mac_unit.sv
// Two-stage MAC datapath: registered product, then accumulate with sticky overflow.
module mac_unit
  import mac_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter bit SIGNED = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_vld_i,
  input  logic              in_first_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [ACC_W-1:0]  acc_o,
  output logic              ovf_o
);

  localparam int P_W = 2 * DATA_W;

  logic [P_W-1:0] a_ext, b_ext;
  (* use_dsp = "yes" *) logic [P_W-1:0] prod;

  logic [P_W-1:0]   p_q;
  logic             p_vld_q, p_first_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] p_ext;
  logic [ACC_W:0]   sum;
  logic             add_ovf;

  // Widening the operands first keeps the low P_W product bits correct for both signednesses.
  assign a_ext = SIGNED ? {{DATA_W{a_i[DATA_W-1]}}, a_i} : {{DATA_W{1'b0}}, a_i};
  assign b_ext = SIGNED ? {{DATA_W{b_i[DATA_W-1]}}, b_i} : {{DATA_W{1'b0}}, b_i};
  assign prod  = a_ext * b_ext;

  assign p_ext   = ACC_W'(ext(EXT_W'(p_q), P_W, SIGNED));
  assign sum     = {1'b0, acc_q} + {1'b0, p_ext};
  assign add_ovf = SIGNED ? ((acc_q[ACC_W-1] == p_ext[ACC_W-1]) &&
                             (sum[ACC_W-1] != acc_q[ACC_W-1]))
                          : sum[ACC_W];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (p_vld_q) begin
      if (p_first_q) begin
        acc_d = p_ext;
        ovf_d = 1'b0;
      end else begin
        acc_d = sum[ACC_W-1:0];
        ovf_d = ovf_q | add_ovf;
      end
    end
  end

  // NOTE: datapath registers are reset too, so the result port reads 0 right after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments only.
      p_q       <= '0;
      p_vld_q   <= 1'b0;
      p_first_q <= 1'b0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      p_q       <= prod;
      p_vld_q   <= in_vld_i;
      p_first_q <= in_first_i;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
    end
  end

  assign acc_o = acc_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/mac_frame_sequencer.sv
// Frame sequencer: joins sample/coefficient streams, runs the MAC for taps beats, hands off the sum.
module mac_frame_sequencer
  import mac_pkg::*;
#(
  parameter  int DATA_W   = DATA_W_DEF,
  parameter  int ACC_W    = ACC_W_DEF,
  parameter  int MAX_TAPS = 9,
  parameter  int SIGNED   = 0,
  localparam int CNT_W    = $clog2(MAX_TAPS + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic [CNT_W-1:0]  cfg_taps,
  input  logic [DATA_W-1:0] i_TDATA,
  input  logic              i_TVALID,
  output logic              i_TREADY,
  input  logic [DATA_W-1:0] k_TDATA,
  input  logic              k_TVALID,
  output logic              k_TREADY,
  output logic [ACC_W-1:0]  o_TDATA,
  output logic              o_TUSER,
  output logic              o_TVALID,
  input  logic              o_TREADY,
  output logic              busy
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] taps_q, taps_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0] taps_clamped;
  logic             fire, last_beat;

  assign fire      = (state_q == ACCUM) && i_TVALID && k_TVALID;
  assign last_beat = fire && (beat_cnt_q == taps_q - CNT_W'(1));

  always_comb begin
    taps_clamped = cfg_taps;
    if (cfg_taps == '0)                    taps_clamped = CNT_W'(1);
    else if (cfg_taps > CNT_W'(MAX_TAPS))  taps_clamped = CNT_W'(MAX_TAPS);
  end

  always_comb begin
    state_d    = state_q;
    taps_d     = taps_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d    = ACCUM;
          taps_d     = taps_clamped;
          beat_cnt_d = '0;
        end
      end
      ACCUM: begin
        if (fire) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (last_beat) state_d = FLUSH;
        end
      end
      // The last product is committed to the accumulator on this edge, so the pipe is empty after it.
      FLUSH:   state_d = OUT;
      OUT:     if (o_TREADY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      taps_q     <= CNT_W'(1);
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      taps_q     <= taps_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .SIGNED (SIGNED != 0)
  ) u_mac (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_vld_i   (fire),
    .in_first_i (fire && (beat_cnt_q == '0)),
    .a_i        (i_TDATA),
    .b_i        (k_TDATA),
    .acc_o      (o_TDATA),
    .ovf_o      (o_TUSER)
  );

  assign i_TREADY = fire;
  assign k_TREADY = fire;
  assign o_TVALID = (state_q == OUT);
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mac_frame_sequencer.sv
// Bench for mac_frame_sequencer: unsigned and signed instances share stimulus, checked against a frame-level model.
module tb_mac_frame_sequencer;

  localparam int DATA_W   = 16;
  localparam int ACC_W    = 32;
  localparam int MAX_TAPS = 9;
  localparam int CNT_W    = 4;

  logic             clk      = 1'b0;
  logic             reset_n  = 1'b0;
  logic             en       = 1'b0;
  logic [CNT_W-1:0] cfg_taps = '0;
  logic [15:0]      i_TDATA  = '0;
  logic [15:0]      k_TDATA  = '0;
  logic             i_TVALID = 1'b0;
  logic             k_TVALID = 1'b0;
  logic             o_TREADY = 1'b0;

  logic        i_rdy_u, k_rdy_u, o_user_u, o_vld_u, busy_u;
  logic        i_rdy_s, k_rdy_s, o_user_s, o_vld_s, busy_s;
  logic [31:0] o_data_u, o_data_s;

  int checks = 0;
  int errors = 0;

  logic [15:0] a_mem [16];
  logic [15:0] b_mem [16];

  always #5 clk = ~clk;

  mac_frame_sequencer #(.DATA_W(DATA_W), .ACC_W(ACC_W), .MAX_TAPS(MAX_TAPS), .SIGNED(0)) u_dut_u (
    .clk(clk), .reset_n(reset_n), .en(en), .cfg_taps(cfg_taps),
    .i_TDATA(i_TDATA), .i_TVALID(i_TVALID), .i_TREADY(i_rdy_u),
    .k_TDATA(k_TDATA), .k_TVALID(k_TVALID), .k_TREADY(k_rdy_u),
    .o_TDATA(o_data_u), .o_TUSER(o_user_u), .o_TVALID(o_vld_u), .o_TREADY(o_TREADY),
    .busy(busy_u)
  );

  mac_frame_sequencer #(.DATA_W(DATA_W), .ACC_W(ACC_W), .MAX_TAPS(MAX_TAPS), .SIGNED(1)) u_dut_s (
    .clk(clk), .reset_n(reset_n), .en(en), .cfg_taps(cfg_taps),
    .i_TDATA(i_TDATA), .i_TVALID(i_TVALID), .i_TREADY(i_rdy_s),
    .k_TDATA(k_TDATA), .k_TVALID(k_TVALID), .k_TREADY(k_rdy_s),
    .o_TDATA(o_data_s), .o_TUSER(o_user_s), .o_TVALID(o_vld_s), .o_TREADY(o_TREADY),
    .busy(busy_s)
  );

  // Frame sum in true integer arithmetic, wrapped to 32 bits after every add; ovf marks any add leaving range.
  function automatic void model(input int n, input bit sgn, output logic [31:0] sum, output logic ovf);
    longint acc, t, p;
    acc = 0;
    ovf = 1'b0;
    for (int j = 0; j < n; j++) begin
      if (sgn) p = longint'($signed(a_mem[j])) * longint'($signed(b_mem[j]));
      else     p = longint'(a_mem[j]) * longint'(b_mem[j]);
      t = acc + p;
      if (sgn) begin
        if (t > 64'sd2147483647 || t < -64'sd2147483648) ovf = 1'b1;
        acc = longint'($signed(t[31:0]));
      end else begin
        if (t >= 64'sd4294967296) ovf = 1'b1;
        acc = t & 64'h0000_0000_FFFF_FFFF;
      end
    end
    sum = acc[31:0];
  endfunction

  task automatic run_frame(input string name, input int cfg, input int k_stall,
                           input bit gaps, input int ready_wait);
    int          eff, idx;
    logic [31:0] exp_u, exp_s;
    logic        ovf_u, ovf_s;
    logic        iv, kv;
    eff = (cfg == 0) ? 1 : ((cfg > MAX_TAPS) ? MAX_TAPS : cfg);
    model(eff, 1'b0, exp_u, ovf_u);
    model(eff, 1'b1, exp_s, ovf_s);

    @(negedge clk);
    en       = 1'b1;
    cfg_taps = CNT_W'(cfg);
    @(negedge clk);
    en       = 1'b0;
    cfg_taps = CNT_W'($urandom_range(0, 15));
    checks++;
    if ({busy_u, busy_s} !== 2'b11) begin
      errors++;
      $display("FAIL %s busy: got %b want 11", name, {busy_u, busy_s});
    end

    idx = 0;
    for (int cyc = 0; idx < eff; cyc++) begin
      if (cyc > 0) @(negedge clk);
      iv = 1'b1;
      kv = 1'b1;
      if (k_stall > 0) begin
        kv = 1'b0;
        k_stall--;
      end else if (gaps) begin
        iv = ($urandom_range(0, 3) != 0);
        kv = ($urandom_range(0, 3) != 0);
      end
      i_TVALID = iv;
      k_TVALID = kv;
      i_TDATA  = iv ? a_mem[idx] : 16'($urandom);
      k_TDATA  = kv ? b_mem[idx] : 16'($urandom);
      #1;
      checks++;
      if ({i_rdy_u, k_rdy_u, i_rdy_s, k_rdy_s} !== {4{iv & kv}}) begin
        errors++;
        $display("FAIL %s join beat %0d: ready got %b want %b", name, idx,
                 {i_rdy_u, k_rdy_u, i_rdy_s, k_rdy_s}, {4{iv & kv}});
      end
      if (iv && kv) idx++;
    end

    // One cycle after the last fire: flushing, nothing valid yet and no further beats accepted.
    @(negedge clk);
    i_TVALID = 1'b1;
    k_TVALID = 1'b1;
    i_TDATA  = 16'($urandom);
    k_TDATA  = 16'($urandom);
    #1;
    checks++;
    if ({i_rdy_u, k_rdy_u, i_rdy_s, k_rdy_s, o_vld_u, o_vld_s} !== 6'b0) begin
      errors++;
      $display("FAIL %s flush: rdy/vld got %b want 000000", name,
               {i_rdy_u, k_rdy_u, i_rdy_s, k_rdy_s, o_vld_u, o_vld_s});
    end

    for (int w = 0; w <= ready_wait; w++) begin
      @(negedge clk);
      o_TREADY = (w == ready_wait);
      i_TDATA  = 16'($urandom);
      k_TDATA  = 16'($urandom);
      #1;
      checks++;
      if ({o_vld_u, o_user_u, o_data_u} !== {1'b1, ovf_u, exp_u}) begin
        errors++;
        $display("FAIL %s unsigned out w=%0d: got vld=%b ovf=%b data=%h want vld=1 ovf=%b data=%h",
                 name, w, o_vld_u, o_user_u, o_data_u, ovf_u, exp_u);
      end
      checks++;
      if ({o_vld_s, o_user_s, o_data_s} !== {1'b1, ovf_s, exp_s}) begin
        errors++;
        $display("FAIL %s signed out w=%0d: got vld=%b ovf=%b data=%h want vld=1 ovf=%b data=%h",
                 name, w, o_vld_s, o_user_s, o_data_s, ovf_s, exp_s);
      end
      checks++;
      if ({i_rdy_u, k_rdy_u, i_rdy_s, k_rdy_s} !== 4'b0) begin
        errors++;
        $display("FAIL %s backpressure w=%0d: ready got %b want 0000", name, w,
                 {i_rdy_u, k_rdy_u, i_rdy_s, k_rdy_s});
      end
    end

    @(negedge clk);
    o_TREADY = 1'b0;
    i_TVALID = 1'b0;
    k_TVALID = 1'b0;
    #1;
    checks++;
    if ({o_vld_u, busy_u, o_vld_s, busy_s} !== 4'b0) begin
      errors++;
      $display("FAIL %s return to idle: vld/busy got %b want 0000", name,
               {o_vld_u, busy_u, o_vld_s, busy_s});
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({o_data_u, o_user_u, o_vld_u, i_rdy_u, k_rdy_u, busy_u} !== 37'b0) begin
      errors++;
      $display("FAIL %s unsigned outputs: data=%h ovf=%b vld=%b rdy=%b%b busy=%b want all 0",
               name, o_data_u, o_user_u, o_vld_u, i_rdy_u, k_rdy_u, busy_u);
    end
    checks++;
    if ({o_data_s, o_user_s, o_vld_s, i_rdy_s, k_rdy_s, busy_s} !== 37'b0) begin
      errors++;
      $display("FAIL %s signed outputs: data=%h ovf=%b vld=%b rdy=%b%b busy=%b want all 0",
               name, o_data_s, o_user_s, o_vld_s, i_rdy_s, k_rdy_s, busy_s);
    end
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    i_TVALID = 1'b1;
    k_TVALID = 1'b1;
    en       = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    en       = 1'b0;
    i_TVALID = 1'b0;
    k_TVALID = 1'b0;
    reset_n  = 1'b1;
  endtask

  task automatic test_basic();
    a_mem[0] = 16'd1; a_mem[1] = 16'd2; a_mem[2] = 16'd3;
    b_mem[0] = 16'd4; b_mem[1] = 16'd5; b_mem[2] = 16'd6;
    run_frame("basic", 3, 0, 1'b0, 0);
  endtask

  task automatic test_backpressure();
    run_frame("backpressure", 3, 0, 1'b0, 5);
  endtask

  task automatic test_sign_extend();
    a_mem[0] = 16'hFFFF;
    b_mem[0] = 16'h0002;
    run_frame("sign_extend", 1, 0, 1'b0, 0);
  endtask

  task automatic test_overflow();
    a_mem[0] = 16'hFFFF; a_mem[1] = 16'hFFFF;
    b_mem[0] = 16'hFFFF; b_mem[1] = 16'hFFFF;
    run_frame("overflow", 2, 0, 1'b0, 1);
    a_mem[0] = 16'd1;
    b_mem[0] = 16'd1;
    run_frame("overflow_clear", 1, 0, 1'b0, 0);
    a_mem[0] = 16'h8000; a_mem[1] = 16'h8000; a_mem[2] = 16'h0001;
    b_mem[0] = 16'h8000; b_mem[1] = 16'h8000; b_mem[2] = 16'h0001;
    run_frame("signed_overflow", 3, 0, 1'b0, 0);
  endtask

  task automatic test_join_stall();
    for (int j = 0; j < 4; j++) begin
      a_mem[j] = 16'($urandom);
      b_mem[j] = 16'($urandom);
    end
    run_frame("join_stall", 4, 4, 1'b0, 0);
  endtask

  task automatic test_boundary();
    for (int j = 0; j < 16; j++) begin
      a_mem[j] = 16'($urandom);
      b_mem[j] = 16'($urandom);
    end
    run_frame("taps_zero", 0, 0, 1'b0, 0);
    run_frame("taps_clamp", 15, 0, 1'b1, 0);
    run_frame("taps_max", MAX_TAPS, 0, 1'b0, 2);
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk);
    en       = 1'b1;
    cfg_taps = 4'd5;
    @(negedge clk);
    en       = 1'b0;
    i_TVALID = 1'b1;
    k_TVALID = 1'b1;
    i_TDATA  = 16'd7;
    k_TDATA  = 16'd9;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_all_zero("reset_mid_frame");
    @(negedge clk);
    reset_n  = 1'b1;
    i_TVALID = 1'b0;
    k_TVALID = 1'b0;
    a_mem[0] = 16'd2;
    b_mem[0] = 16'd3;
    run_frame("after_reset", 1, 0, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int f = 0; f < 25; f++) begin
      for (int j = 0; j < 16; j++) begin
        case ($urandom_range(0, 3))
          0:       a_mem[j] = 16'hFFFF;
          1:       a_mem[j] = 16'h8000;
          default: a_mem[j] = 16'($urandom);
        endcase
        case ($urandom_range(0, 3))
          0:       b_mem[j] = 16'hFFFF;
          1:       b_mem[j] = 16'h8000;
          default: b_mem[j] = 16'($urandom);
        endcase
      end
      run_frame($sformatf("random%0d", f), $urandom_range(0, 15), $urandom_range(0, 2),
                1'b1, $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_sign_extend();
    test_overflow();
    test_join_stall();
    test_boundary();
    test_reset_mid_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
